// File: rtl/shared_line_arbiter.sv
// Round-robin arbiter that drives a granted word onto a shared line,
// holds it, reads the resolved value back and flags contention.
module shared_line_arbiter #(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int HOLD_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         grant,
  output logic [W-1:0]         bus_out,
  output logic                 bus_oe,
  input  logic [W-1:0]         bus_in,
  output logic                 done,
  output logic                 contention,
  output logic [CNT_W-1:0]     contention_cnt,
  output logic [$clog2(N)-1:0] rr_ptr
);

  localparam int PW = $clog2(N);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    DRIVE,
    SAMPLE,
    RELEASE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] win_q;
  logic          win_found;
  logic          mismatch;

  // First asserted request at or above rr_ptr, wrapping past N-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!win_found && req[(int'(rr_ptr) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(rr_ptr) + k) % N);
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|req) state_nx = ARB;
      ARB:     state_nx = win_found ? DRIVE : IDLE;
      DRIVE: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1))
          state_nx = SAMPLE;
      end
      SAMPLE:  state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus_oe = (state == DRIVE) || (state == SAMPLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= '0;
      bus_out        <= '0;
      done           <= 1'b0;
      contention     <= 1'b0;
      contention_cnt <= '0;
      rr_ptr         <= '0;
      hold_cnt       <= '0;
      mismatch       <= 1'b0;
      win_q          <= '0;
    end else begin
      state      <= state_nx;
      done       <= 1'b0;
      contention <= 1'b0;
      unique case (state)
        ARB: begin
          if (win_found) begin
            grant    <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            bus_out  <= req_data[win_idx*W +: W];
            win_q    <= win_idx;
            hold_cnt <= '0;
          end
        end
        DRIVE: hold_cnt <= hold_cnt + 1'b1;
        // x/z on the readback must count as a mismatch
        SAMPLE: mismatch <= (bus_in !== bus_out);
        RELEASE: begin
          done       <= 1'b1;
          contention <= mismatch;
          grant      <= '0;
          if (mismatch && contention_cnt != '1)
            contention_cnt <= contention_cnt + 1'b1;
          rr_ptr <= (win_q == PW'(N - 1)) ? '0 : win_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_line_arbiter.sv
// Scoreboard bench: stimulus queues expected transactions, a negedge
// monitor pops and compares on every done pulse.
module tb_shared_line_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 3;
  localparam int CW   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic           force_en = 1'b0;
  logic [N-1:0]   grant;
  logic [W-1:0]   bus_out;
  logic           bus_oe;
  logic [W-1:0]   bus_in;
  logic           done;
  logic           contention;
  logic [CW-1:0]  contention_cnt;
  logic [1:0]     rr_ptr;

  // Forced mode emulates an external strong 0 winning the wired net.
  assign bus_in = force_en ? 8'h00 : bus_out;

  always #5 clk = ~clk;

  shared_line_arbiter #(
    .N(N), .W(W), .HOLD_CYCLES(HOLD), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .grant(grant),
    .bus_out(bus_out),
    .bus_oe(bus_oe),
    .bus_in(bus_in),
    .done(done),
    .contention(contention),
    .contention_cnt(contention_cnt),
    .rr_ptr(rr_ptr)
  );

  typedef struct {
    logic [N-1:0]  g;
    logic [W-1:0]  d;
    logic          c;
    logic [CW-1:0] n;
    logic [1:0]    p;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int grants_seen = 0;
  int dones_seen = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] g, input logic [W-1:0] d,
                      input logic c, input logic [CW-1:0] n,
                      input logic [1:0] p);
    exp_t e;
    e.g = g; e.d = d; e.c = c; e.n = n; e.p = p;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grants(input int target);
    int n;
    n = 0;
    while (grants_seen < target && n < 100) begin
      tick();
      n++;
    end
    if (grants_seen < target) check("grant_timeout", grants_seen, target);
  endtask

  task automatic wait_dones(input int target);
    int n;
    n = 0;
    while (dones_seen < target && n < 100) begin
      tick();
      n++;
    end
    if (dones_seen < target) check("done_timeout", dones_seen, target);
  endtask

  // Monitor
  initial begin
    logic [N-1:0] pg;
    logic [N-1:0] cg;
    logic [W-1:0] cd;
    int oe;
    exp_t e;
    pg = '0; cg = '0; cd = '0; oe = 0;
    forever begin
      @(negedge clk);
      if (grant != 0 && pg == 0) begin
        cg = grant;
        cd = bus_out;
        oe = 0;
        grants_seen++;
      end
      if (bus_oe) oe++;
      if (done) begin
        dones_seen++;
        if (q.size() == 0) begin
          check("spurious_done", 32'(done), 0);
        end else begin
          e = q.pop_front();
          check("grant", 32'(cg), 32'(e.g));
          check("bus_out", 32'(cd), 32'(e.d));
          check("contention", 32'(contention), 32'(e.c));
          check("cnt", 32'(contention_cnt), 32'(e.n));
          check("rr_ptr", 32'(rr_ptr), 32'(e.p));
          check("oe_cycles", oe, HOLD + 1);
          check("grant_clear", 32'(grant), 0);
        end
      end else if (contention) begin
        check("stray_contention", 32'(contention), 0);
      end
      pg = grant;
    end
  end

  // Stimulus
  initial begin
    logic seen;
    int n;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_bus_out", 32'(bus_out), 0);
    check("rst_oe", 32'(bus_oe), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cont", 32'(contention), 0);
    check("rst_cnt", 32'(contention_cnt), 0);
    check("rst_ptr", 32'(rr_ptr), 0);
    rst = 1'b0;
    tick();

    // Single requester
    req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
    push(4'b0001, 8'hA5, 1'b0, 2'd0, 2'd1);
    req = 4'b0001;
    tick();
    check("lat_ifidle", 32'(grant), 0);
    tick();
    check("lat_grant", 32'(grant), 32'h1);
    wait_grants(1);
    req = '0;
    wait_dones(1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ptr_after_rst", 32'(rr_ptr), 0);

    // Round-robin with all requesting
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    push(4'b0001, 8'h11, 1'b0, 2'd0, 2'd1);
    push(4'b0010, 8'h22, 1'b0, 2'd0, 2'd2);
    push(4'b0100, 8'h33, 1'b0, 2'd0, 2'd3);
    push(4'b1000, 8'h44, 1'b0, 2'd0, 2'd0);
    push(4'b0001, 8'h11, 1'b0, 2'd0, 2'd1);
    req = 4'b1111;
    wait_grants(6);
    req = '0;
    wait_dones(6);

    // Forced contention, counter saturates at 3
    force_en = 1'b1;
    req_data = {N{8'hFF}};
    for (int i = 0; i < 5; i++) begin
      push(4'(1 << ((1 + i) % 4)), 8'hFF, 1'b1,
           2'((i + 1 > 3) ? 3 : i + 1), 2'((2 + i) % 4));
      req = 4'(1 << ((1 + i) % 4));
      wait_grants(7 + i);
      req = '0;
      wait_dones(7 + i);
    end
    force_en = 1'b0;

    // Reset during the second DRIVE cycle
    req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
    req = 4'b0100;
    n = 0;
    while (grant == 0 && n < 20) begin
      tick();
      n++;
    end
    check("mid_grant", 32'(grant), 32'h4);
    tick();
    rst = 1'b1;
    tick();
    check("mid_oe", 32'(bus_oe), 0);
    check("mid_grant_clr", 32'(grant), 0);
    check("mid_ptr", 32'(rr_ptr), 0);
    check("mid_cnt", 32'(contention_cnt), 0);
    check("mid_done", 32'(done), 0);
    rst = 1'b0;
    req = '0;
    repeat (10) tick();

    // Request withdrawn while in ARB
    req = 4'b0100;
    tick();
    req = '0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (grant != 0 || bus_oe) seen = 1'b1;
    end
    check("withdraw", 32'(seen), 0);

    // Arbiter is idle again and serves a fresh request
    req_data = {8'h00, 8'h00, 8'h00, 8'hC3};
    push(4'b0001, 8'hC3, 1'b0, 2'd0, 2'd1);
    req = 4'b0001;
    tick();
    check("lat2_ifidle", 32'(grant), 0);
    tick();
    check("lat2_grant", 32'(grant), 32'h1);
    wait_grants(13);
    req = '0;
    wait_dones(12);
    repeat (3) tick();
    check("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_line_arbiter.md
Name: shared_line_arbiter

Overview:
- Round-robin arbiter and driver for a shared multi-driver line of width W.
- Grants one of N requesters, drives its word onto the line at strong strength for a fixed hold window, then reads back the resolved net value.
- Flags contention whenever the resolved value differs from the driven word, e.g. when an external strong driver overrides ours.
- Sits directly upstream of the resolved net: it produces the driver side that the net resolution consumes.

Parameters:
N, 4, number of requesters (2..16)
W, 8, line width in bits
HOLD_CYCLES, 3, cycles line is driven before readback (>=1)
CNT_W, 8, width of saturating contention counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req  input  N  per-requester request, level; held until grant seen
req_data  input  N*W  requester i word at bits [i*W +: W]
grant  output  N  one-hot grant, held for whole transaction
bus_out  output  W  word driven onto line
bus_oe  output  1  1 = drive bus_out at strong strength; 0 = release (weak pull only)
bus_in  input  W  resolved line value readback
done  output  1  1-cycle pulse at end of each transaction
contention  output  1  1-cycle pulse, coincident with done, when readback mismatched
contention_cnt  output  CNT_W  saturating count of contention events
rr_ptr  output  clog2(N)  current round-robin priority index (debug)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - grant=0, bus_out=0, bus_oe=0, done=0, contention=0, contention_cnt=0, rr_ptr=0, state=IDLE.
  - Reset is honoured mid-transaction: bus_oe drops the cycle after rst is sampled high.
- States:
  - IDLE: if any req, go to ARB; else stay.
  - ARB: pick the first asserted req searching from rr_ptr upward with wrap (index N-1 wraps to 0). Register grant one-hot and latch bus_out = req_data of the winner. Go to DRIVE. If req dropped to all-zero in this cycle, return to IDLE with no grant.
  - DRIVE: bus_oe=1, grant held, bus_out frozen (later req_data changes are ignored). Stay exactly HOLD_CYCLES cycles (internal counter), then go to SAMPLE.
  - SAMPLE: bus_oe still 1. Compare bus_in with bus_out.
    - Mismatch: contention=1 next cycle, and contention_cnt+1 saturating at 2^CNT_W-1.
    - Go to RELEASE.
  - RELEASE: bus_oe=0, one turnaround cycle. done=1 (and contention if flagged). grant cleared. rr_ptr = (winner+1) mod N. Go to IDLE.
- Latency:
  - req rise to grant: 2 cycles (IDLE, ARB).
  - grant to done: HOLD_CYCLES+2 cycles.
  - Minimum spacing between back-to-back transactions: HOLD_CYCLES+4 cycles.
- A requester dropping req while granted does not abort the transaction; the word still completes.
- Readback while in IDLE, ARB or RELEASE is ignored (no contention check).
- bus_in containing x/z at SAMPLE counts as mismatch (use a case-inequality compare).
- Fairness: a continuously requesting agent waits at most N-1 transactions.

Test Plan:
- Single requester: N=4, W=8, HOLD_CYCLES=3. req=0001, data0=0xA5, bus_in mirrors bus_out.
  -> grant=0001 two cycles after req; bus_oe high 4 cycles; done pulse; contention=0; cnt=0; rr_ptr=1.
- Round-robin: req=1111 held continuously with distinct data.
  -> grants in order 0001, 0010, 0100, 1000, 0001; each bus_out matches its requester's data.
- Contention: bench forces bus_in=0x00 while bus_out=0xFF at SAMPLE (emulates strong0 overriding our strong1 on a wired net).
  -> contention and done pulse together; contention_cnt=1.
- Saturation: CNT_W=2, five forced contentions.
  -> contention_cnt sequence 1, 2, 3, 3, 3.
- Reset mid-DRIVE: assert rst during the second DRIVE cycle.
  -> the next cycle shows bus_oe=0, grant=0, no done pulse, rr_ptr=0, cnt=0.
- req withdrawn in ARB: req=0100 for exactly 1 cycle.
  -> no grant issued, bus_oe never asserted, state back to IDLE.
